mem_responder: RTL

Memory-side responder for the CVP14 scalar/vector memory bus: the target end of the RD/WR/Addr/DataIn/DataOut protocol that CVP14 initiates. It owns a synchronous word array, accepts single-word and 16-word burst requests, inserts a fixed access latency, and signals each returned or accepted word with a one-cycle Valid strobe. It replaces the behavioural DRAM in system benches and is the synthesizable memory target for the vector load/store path.

---
 rtl/mem_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side target for the CVP14 RD/WR/Addr/DataIn/DataOut bus.
//
// Owns a 2^ADDR_BITS x 16-bit synchronous array. A request is accepted at a rising
// edge while Busy=0 with exactly one of RD/WR high. After LATENCY cycles the
// transfer returns (read) or consumes (write) one word per cycle, flagged by Valid.
//
// Parameters:
//   ADDR_BITS  array index width (4..16); the upper address bits alias
//   LATENCY    cycles from acceptance to the first Valid (1..7)
//
// Ports:
//   Clk1     in   system clock, rising edge
//   Reset_l  in   synchronous reset, active-low
//   RD, WR   in   read / write request, sampled while Busy=0
//   Burst    in   16-beat transfer wrapping inside the aligned 16-word block
//   Addr     in   word address, captured at acceptance
//   DataIn   in   write data, sampled at the edge ending each write Valid cycle
//   DataOut  out  registered read data, 0 outside read beats
//   Valid    out  one beat returned (read) or consumed (write)
//   Busy     out  transfer in progress; requests are ignored
//   Err      out  one-cycle pulse after an accept edge with RD and WR both high
//
// Build option: define MEMRESP_BURST_EN to honour Burst. Without it, Burst is
// ignored and every transfer is a single beat.
module mem_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        Clk1,
    input  logic        Reset_l,
    input  logic        RD,
    input  logic        WR,
    input  logic        Burst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Valid,
    output logic        Busy,
    output logic        Err
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    typedef logic [ADDR_BITS-1:0] idx_t;
    typedef enum logic [1:0] {StIdle, StWait, StXfer} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    idx_t        addr_q, addr_d;
    logic        is_rd_q, is_rd_d;
    logic        err_q, err_d;
    logic [15:0] dout_q;
    logic [15:0] mem [Depth];

    logic        last_beat;
    logic        mem_we;
    logic        rd_next;   // the coming cycle is a read beat
    idx_t        rd_idx;    // array index of that read beat
    idx_t        wr_idx;    // array index of the current beat
    idx_t        nxt_idx;   // array index of the following beat

    // Upper address bits beyond ADDR_BITS alias and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^Addr;

`ifdef MEMRESP_BURST_EN
    localparam idx_t LowMask = idx_t'(16'h000f);

    logic [3:0] beat_q, beat_d;
    logic       burst_q, burst_d;

    // Keep the upper index bits, wrap the low nibble inside the 16-word block.
    function automatic idx_t beat_idx(idx_t base, logic [3:0] beat);
        idx_t sum;
        sum = base + idx_t'(beat);
        return (base & ~LowMask) | (sum & LowMask);
    endfunction

    assign last_beat = !burst_q || (beat_q == 4'hf);
    assign wr_idx    = beat_idx(addr_q, beat_q);
    assign nxt_idx   = beat_idx(addr_q, beat_q + 4'd1);

    always_ff @(posedge Clk1) begin
        if (!Reset_l) begin
            beat_q  <= 4'd0;
            burst_q <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            burst_q <= burst_d;
        end
    end
`else
    logic unused_burst;
    assign unused_burst = Burst;

    assign last_beat = 1'b1;
    assign wr_idx    = addr_q;
    assign nxt_idx   = addr_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        is_rd_d = is_rd_q;
        err_d   = 1'b0;
        rd_next = 1'b0;
        rd_idx  = addr_q;
        mem_we  = 1'b0;
`ifdef MEMRESP_BURST_EN
        beat_d  = beat_q;
        burst_d = burst_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (RD && WR) begin
                    err_d = 1'b1;
                end else if (RD || WR) begin
                    addr_d  = Addr[ADDR_BITS-1:0];
                    is_rd_d = RD;
`ifdef MEMRESP_BURST_EN
                    burst_d = Burst;
                    beat_d  = 4'd0;
`endif
                    if (LATENCY == 1) begin
                        // No wait state: the first read word is fetched at the accept edge.
                        state_d = StXfer;
                        rd_next = RD;
                        rd_idx  = Addr[ADDR_BITS-1:0];
                    end else begin
                        state_d = StWait;
                        cnt_d   = 3'(LATENCY - 2);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StXfer;
                    rd_next = is_rd_q;
                    rd_idx  = addr_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StXfer: begin
                mem_we = !is_rd_q;
                if (last_beat) begin
                    state_d = StIdle;
                end else begin
`ifdef MEMRESP_BURST_EN
                    beat_d = beat_q + 4'd1;
`endif
                    rd_next = is_rd_q;
                    rd_idx  = nxt_idx;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk1) begin
        if (!Reset_l) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            is_rd_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            is_rd_q <= is_rd_d;
            err_q   <= err_d;
            dout_q  <= rd_next ? mem[rd_idx] : 16'h0000;
        end
    end

    // Array is never reset; a reset edge suppresses the write of the beat it ends.
    always_ff @(posedge Clk1) begin
        if (Reset_l && mem_we) begin
            mem[wr_idx] <= DataIn;
        end
    end

    assign DataOut = dout_q;
    assign Valid   = (state_q == StXfer);
    assign Busy    = (state_q != StIdle);
    assign Err     = err_q;

endmodule
